// File: rtl/ones_pkg.sv
// ones_pkg: shared widths and state encoding for the ones-counter frame collector
package ones_pkg;
    localparam int N     = 6;
    localparam int WORD  = 2 ** (N + 1) - 1;
    localparam int CNT_W = N + 1;
    localparam int IDX_W = $clog2(WORD);
    typedef enum logic [1:0] {COLLECT, LATCH, DONE} ofc_state_t;
endpackage

// File: rtl/ones_bit_index_ctr.sv
// ones_bit_index_ctr: bit position counter for frame assembly, wraps to 0 after WORD-1
module ones_bit_index_ctr
    import ones_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_term
);
    logic [IDX_W-1:0] r_idx;
    assign o_idx  = r_idx;
    assign o_term = r_idx == IDX_W'(WORD - 1);
    // advance on each accepted bit, wrapping at the end of the frame
    always_ff @(posedge clk)
        if (rst || i_clr) r_idx <= '0;
        else if (i_en)    r_idx <= o_term ? '0 : r_idx + 1'b1;
endmodule

// File: rtl/ones_frame_collector.sv
// ones_frame_collector: assembles a serial frame for the popcount tree and registers its count
module ones_frame_collector
    import ones_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [WORD-1:0]  frame_out,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready
);
    ofc_state_t       r_state;
    logic [WORD-1:0]  r_frame;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_valid;
    logic             r_ser_ready;
    logic [IDX_W-1:0] w_idx;
    logic             w_term;
    logic             w_accept;
    assign w_accept  = ser_valid & r_ser_ready;
    assign ser_ready = r_ser_ready;
    assign frame_out = r_frame;
    assign cnt_out   = r_cnt;
    assign cnt_valid = r_cnt_valid;
    ones_bit_index_ctr u_idx (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (clr),
        .i_en   (w_accept),
        .o_idx  (w_idx),
        .o_term (w_term)
    );
    // frame assembly, count capture and drain handshake; clr aborts but keeps the last count
    always_ff @(posedge clk)
        if (rst) begin
            r_state     <= COLLECT;
            r_frame     <= '0;
            r_cnt       <= '0;
            r_cnt_valid <= 1'b0;
            r_ser_ready <= 1'b1;
        end else if (clr) begin
            r_state     <= COLLECT;
            r_frame     <= '0;
            r_cnt_valid <= 1'b0;
            r_ser_ready <= 1'b1;
        end else begin
            unique case (r_state)
                COLLECT: if (w_accept) begin
                    r_frame[w_idx] <= ser_in;
                    if (w_term) begin
                        r_state     <= LATCH;
                        r_ser_ready <= 1'b0;
                    end
                end
                LATCH: begin
                    r_cnt       <= cnt_in;
                    r_cnt_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (cnt_ready) begin
                    r_cnt_valid <= 1'b0;
                    r_frame     <= '0;
                    r_ser_ready <= 1'b1;
                    r_state     <= COLLECT;
                end
                default: r_state <= COLLECT;
            endcase
        end
endmodule

// File: tb/tb_ones_frame_collector.sv
// tb_ones_frame_collector: randomized frame traffic checked against a bit-list reference model
module tb_ones_frame_collector;
    import ones_pkg::*;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             cnt_ready = 1'b0;
    logic             ser_ready;
    logic             cnt_valid;
    logic [WORD-1:0]  frame_out;
    logic [CNT_W-1:0] cnt_in;
    logic [CNT_W-1:0] cnt_out;
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               m_last = 0;
    logic [WORD-1:0]  m_frame = '0;

    ones_frame_collector dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .frame_out (frame_out),
        .cnt_in    (cnt_in),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready)
    );

    // stands in for the external combinational popcount tree
    assign cnt_in = CNT_W'($countones(frame_out));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_frame"}, 128'(frame_out), 128'(0));
        chk({tag, "_cnt"},   128'(cnt_out),   128'(0));
        chk({tag, "_valid"}, 128'(cnt_valid), 128'(0));
        chk({tag, "_ready"}, 128'(ser_ready), 128'(1));
    endtask

    // mode: 0 zeros, 1 ones, 2 alternating from 1, 3 random; gap: 0 none, 1 every 3rd cycle, 2 random
    task automatic feed(input int mode, input int gap, input int nbits);
        int ones;
        m_frame = '0;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            int   tries;
            b = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? 1'(i % 2 == 0) : 1'($urandom % 2);
            tries = 0;
            forever begin
                logic take;
                ser_in    = b;
                ser_valid = gap == 1 ? 1'(cyc % 3 != 2) : gap == 2 ? 1'($urandom % 4 != 0) : 1'b1;
                cnt_ready = 1'($urandom % 2);
                take = ser_valid && ser_ready;
                tick;
                tries++;
                if (take) break;
                if (tries > 8) begin
                    chk("accept_timeout", 128'(0), 128'(1));
                    break;
                end
            end
            m_frame[i] = b;
            ones += int'(b);
        end
        ser_valid = 1'b0;
        cnt_ready = 1'b0;
        if (nbits == WORD) begin
            chk("latch_ready", 128'(ser_ready), 128'(0));
            chk("latch_valid", 128'(cnt_valid), 128'(0));
            chk("latch_frame", 128'(frame_out), 128'(m_frame));
            chk("latch_cnt_held", 128'(cnt_out), 128'(m_last));
            tick;
            chk("done_valid", 128'(cnt_valid), 128'(1));
            chk("done_cnt", 128'(cnt_out), 128'(ones));
            chk("done_ready", 128'(ser_ready), 128'(0));
            m_last = ones;
        end else begin
            chk("partial_frame", 128'(frame_out), 128'(m_frame));
        end
    endtask

    task automatic drain(input int hold);
        cnt_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            ser_valid = 1'b1;
            ser_in    = 1'($urandom % 2);
            tick;
            chk("hold_valid", 128'(cnt_valid), 128'(1));
            chk("hold_cnt",   128'(cnt_out),   128'(m_last));
            chk("hold_frame", 128'(frame_out), 128'(m_frame));
            chk("hold_ready", 128'(ser_ready), 128'(0));
        end
        ser_valid = 1'b0;
        cnt_ready = 1'b1;
        tick;
        cnt_ready = 1'b0;
        chk("drain_valid", 128'(cnt_valid), 128'(0));
        chk("drain_ready", 128'(ser_ready), 128'(1));
        chk("drain_frame", 128'(frame_out), 128'(0));
        chk("drain_cnt",   128'(cnt_out),   128'(m_last));
    endtask

    initial begin
        tick;
        tick;
        rst = 1'b0;
        chk_reset("reset");
        feed(1, 0, WORD);
        chk("all_ones", 128'(cnt_out), 128'(127));
        drain(0);
        feed(0, 0, WORD);
        drain(2);
        feed(2, 0, WORD);
        chk("alt_cnt", 128'(cnt_out), 128'(64));
        drain(1);
        feed(2, 1, WORD);
        chk("alt_gap_cnt", 128'(cnt_out), 128'(64));
        drain(0);
        feed(3, 2, WORD);
        drain(5);
        feed(3, 0, 50);
        rst = 1'b1;
        ser_valid = 1'b1;
        tick;
        rst = 1'b0;
        ser_valid = 1'b0;
        m_last = 0;
        chk_reset("rst_mid");
        feed(1, 0, WORD);
        drain(0);
        feed(3, 2, 50);
        clr = 1'b1;
        ser_valid = 1'b1;
        ser_in = 1'b1;
        tick;
        clr = 1'b0;
        ser_valid = 1'b0;
        chk("clr_frame", 128'(frame_out), 128'(0));
        chk("clr_valid", 128'(cnt_valid), 128'(0));
        chk("clr_ready", 128'(ser_ready), 128'(1));
        chk("clr_cnt",   128'(cnt_out),   128'(m_last));
        feed(2, 0, WORD);
        drain(0);
        feed(3, 0, WORD);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_done_valid", 128'(cnt_valid), 128'(0));
        chk("clr_done_frame", 128'(frame_out), 128'(0));
        chk("clr_done_ready", 128'(ser_ready), 128'(1));
        chk("clr_done_cnt",   128'(cnt_out),   128'(m_last));
        for (int r = 0; r < 6; r++) begin
            feed(3, int'($urandom % 3), WORD);
            drain(int'($urandom % 4));
        end
        feed(1, 0, WORD);
        rst = 1'b1;
        clr = 1'b1;
        tick;
        rst = 1'b0;
        clr = 1'b0;
        m_last = 0;
        chk_reset("rst_clr_done");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
